// File: rtl/instr_sequencer.sv
// Instruction sequencer: loadable instruction store, PC stepping and valid/stall handoff to execute.
// Optional single-step gating is enabled with `define SEQ_SINGLE_STEP_EN (adds step_mode/step inputs).

package instr_seq_pkg;

  typedef enum logic [2:0] {
    ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_SLL, ALU_SRL, ALU_PASS
  } alu_op_t;

  typedef logic [4:0]  reg_address_t;
  typedef logic [15:0] immediate_t;

  typedef struct packed {
    logic alu_use_imm;
    logic is_ebreak;
  } instr_flags_t;

  typedef struct packed {
    instr_flags_t flags;
    alu_op_t      op;
    reg_address_t dst;
    reg_address_t src1;
    reg_address_t src2;
    immediate_t   imm;
  } instr_t;

endpackage

module instr_sequencer
  import instr_seq_pkg::*;
#(
  parameter int DEPTH  = 32,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              load_en,
  input  logic [ADDR_W-1:0] load_addr,
  input  instr_t            load_data,
  input  logic              start,
  input  logic              stall,
`ifdef SEQ_SINGLE_STEP_EN
  input  logic              step_mode,
  input  logic              step,
`endif
  output logic              valid,
  output instr_flags_t      flags,
  output alu_op_t           op,
  output reg_address_t      dst,
  output reg_address_t      src1,
  output reg_address_t      src2,
  output immediate_t        imm,
  output logic [ADDR_W-1:0] pc,
  output logic              busy,
  output logic              halted,
  output logic              overrun
);

  typedef enum logic [1:0] {IDLE, RUN, HALT} state_t;

  state_t            state, state_next;
  instr_t            store [DEPTH];
  instr_t            cur;
  logic              launch;
  logic              transfer;
  logic              step_ok;
  logic [ADDR_W-1:0] pc_inc;

  assign launch   = start && (state != RUN);
  assign transfer = (state == RUN) && valid && !stall && step_ok;
  assign pc_inc   = pc + 1'b1;

`ifdef SEQ_SINGLE_STEP_EN
  logic step_q;
  logic step_pend;
  logic step_rise;

  assign step_rise = step && !step_q;
  // A rising edge seen while stalled is remembered so the pulse still advances once.
  assign step_ok   = !step_mode || step_rise || step_pend;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      step_q    <= 1'b0;
      step_pend <= 1'b0;
    end else begin
      step_q <= step;
      if (transfer || (state != RUN)) step_pend <= 1'b0;
      else if (step_rise)             step_pend <= 1'b1;
    end
  end
`else
  assign step_ok = 1'b1;
`endif

  // NOTE: the store is plain RAM with no reset; its contents must survive reset_n.
  always_ff @(posedge clk) begin
    if (load_en && !launch && (state != RUN)) store[load_addr] <= load_data;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_next;
  end

  // NOTE: the default assignment first keeps this block free of inferred latches.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE, HALT: if (start) state_next = RUN;
      RUN:        if (transfer && cur.flags.is_ebreak) state_next = HALT;
      default:    state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pc      <= '0;
      valid   <= 1'b0;
      cur     <= '0;
      busy    <= 1'b0;
      halted  <= 1'b0;
      overrun <= 1'b0;
    end else begin
      busy   <= (state_next == RUN);
      halted <= (state_next == HALT);
      if (launch) begin
        pc      <= '0;
        valid   <= 1'b1;
        cur     <= store[0];
        overrun <= 1'b0;
      end else if (transfer) begin
        if (cur.flags.is_ebreak) begin
          valid <= 1'b0;
        end else begin
          pc  <= pc_inc;
          cur <= store[pc_inc];
          if (pc == ADDR_W'(DEPTH - 1)) overrun <= 1'b1;
        end
      end
    end
  end

  assign flags = cur.flags;
  assign op    = cur.op;
  assign dst   = cur.dst;
  assign src1  = cur.src1;
  assign src2  = cur.src2;
  assign imm   = cur.imm;

endmodule

// File: tb/tb_instr_sequencer.sv
// Directed bench for instr_sequencer with a small register-file/ALU consumer model.
// Step-mode checks are included when SEQ_SINGLE_STEP_EN is defined.

module tb_instr_sequencer;
  import instr_seq_pkg::*;

  logic         clk = 1'b0;
  logic         reset_n;
  logic         load_en, start, stall;
  logic [4:0]   load_addr;
  instr_t       load_data;
  logic         valid, busy, halted, overrun;
  instr_flags_t flags;
  alu_op_t      op;
  reg_address_t dst, src1, src2;
  immediate_t   imm;
  logic [4:0]   pc;

  logic         load_en_w, start_w;
  logic [1:0]   load_addr_w;
  instr_t       load_data_w;
  logic         valid_w, busy_w, halted_w, overrun_w;
  instr_flags_t flags_w;
  alu_op_t      op_w;
  reg_address_t dst_w, src1_w, src2_w;
  immediate_t   imm_w;
  logic [1:0]   pc_w;

`ifdef SEQ_SINGLE_STEP_EN
  logic step_mode, step;
`endif

  int n_cmp  = 0;
  int n_fail = 0;

  instr_t      prog [8];
  logic [31:0] regs [32];
  bit          model_en = 1'b0;
  logic [31:0] a, b, r;

  always #5 clk = ~clk;

  instr_sequencer #(.DEPTH(32)) u_dut (
    .clk(clk), .reset_n(reset_n), .load_en(load_en), .load_addr(load_addr),
    .load_data(load_data), .start(start), .stall(stall),
`ifdef SEQ_SINGLE_STEP_EN
    .step_mode(step_mode), .step(step),
`endif
    .valid(valid), .flags(flags), .op(op), .dst(dst), .src1(src1), .src2(src2),
    .imm(imm), .pc(pc), .busy(busy), .halted(halted), .overrun(overrun)
  );

  instr_sequencer #(.DEPTH(4)) u_wrap (
    .clk(clk), .reset_n(reset_n), .load_en(load_en_w), .load_addr(load_addr_w),
    .load_data(load_data_w), .start(start_w), .stall(1'b0),
`ifdef SEQ_SINGLE_STEP_EN
    .step_mode(1'b0), .step(1'b0),
`endif
    .valid(valid_w), .flags(flags_w), .op(op_w), .dst(dst_w), .src1(src1_w), .src2(src2_w),
    .imm(imm_w), .pc(pc_w), .busy(busy_w), .halted(halted_w), .overrun(overrun_w)
  );

  // Consumer model: retires each accepted non-ebreak instruction into a register file.
  always @(negedge clk) begin
    if (!model_en) begin
      for (int i = 0; i < 32; i++) regs[i] = '0;
    end else if (reset_n && valid && !stall && !flags.is_ebreak) begin
      a = regs[src1];
      b = flags.alu_use_imm ? 32'(imm) : regs[src2];
      case (op)
        ALU_ADD: r = a + b;
        ALU_SUB: r = a - b;
        ALU_AND: r = a & b;
        ALU_OR:  r = a | b;
        ALU_XOR: r = a ^ b;
        default: r = b;
      endcase
      if (dst != 0) regs[dst] = r;
    end
  end

  function automatic instr_t mk(input logic ui, input logic eb, input alu_op_t o,
                                input int d, input int s1, input int s2, input int im);
    instr_t t;
    t.flags.alu_use_imm = ui;
    t.flags.is_ebreak   = eb;
    t.op   = o;
    t.dst  = reg_address_t'(d);
    t.src1 = reg_address_t'(s1);
    t.src2 = reg_address_t'(s2);
    t.imm  = immediate_t'(im);
    return t;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_model();
    model_en = 1'b0;
    tick();
    model_en = 1'b1;
  endtask

  task automatic run_to_halt(input int max_cycles);
    for (int n = 0; n < max_cycles && !halted; n++) tick();
    check("halt_reached", 32'(halted), 32'd1);
  endtask

  task automatic check_regs(input string tag);
    check({tag, "_r1"}, regs[1], 32'd50);
    check({tag, "_r2"}, regs[2], 32'd60);
    check({tag, "_r3"}, regs[3], 32'd61);
    check({tag, "_r4"}, regs[4], 32'd62);
    check({tag, "_r5"}, regs[5], 32'd12);
    check({tag, "_r6"}, regs[6], 32'd48);
  endtask

  initial begin
    reset_n = 1'b0; load_en = 1'b0; start = 1'b0; stall = 1'b0;
    load_addr = '0; load_data = '0;
    load_en_w = 1'b0; start_w = 1'b0; load_addr_w = '0; load_data_w = '0;
`ifdef SEQ_SINGLE_STEP_EN
    step_mode = 1'b0; step = 1'b0;
`endif
    prog[0] = mk(1, 0, ALU_ADD, 1, 0, 0, 10);
    prog[1] = mk(1, 0, ALU_ADD, 1, 1, 0, 40);
    prog[2] = mk(1, 0, ALU_ADD, 2, 1, 0, 10);
    prog[3] = mk(1, 0, ALU_ADD, 3, 2, 0, 1);
    prog[4] = mk(1, 0, ALU_ADD, 4, 3, 0, 1);
    prog[5] = mk(0, 0, ALU_SUB, 5, 4, 1, 0);
    prog[6] = mk(0, 0, ALU_AND, 6, 1, 2, 0);
    prog[7] = mk(0, 1, ALU_ADD, 0, 0, 0, 0);

    tick(); tick();
    reset_n = 1'b1;
    check("rst_pc",      32'(pc),      32'd0);
    check("rst_valid",   32'(valid),   32'd0);
    check("rst_busy",    32'(busy),    32'd0);
    check("rst_halted",  32'(halted),  32'd0);
    check("rst_overrun", 32'(overrun), 32'd0);
    check("rst_fields",  32'({dst, imm}), 32'd0);

    for (int i = 0; i < 8; i++) begin
      load_en = 1'b1; load_addr = 5'(i); load_data = prog[i];
      tick();
    end
    load_en = 1'b0;

    // Straight run: one instruction per cycle, halt after ebreak.
    clear_model();
    start = 1'b1; tick(); start = 1'b0;
    check("run_busy",   32'(busy), 32'd1);
    check("run_dst0",   32'(dst),  32'd1);
    check("run_imm0",   32'(imm),  32'd10);
    for (int i = 0; i < 8; i++) begin
      check($sformatf("run_pc%0d", i),    32'(pc),    32'(i));
      check($sformatf("run_valid%0d", i), 32'(valid), 32'd1);
      tick();
    end
    check("halt_halted",  32'(halted),  32'd1);
    check("halt_pc",      32'(pc),      32'd7);
    check("halt_valid",   32'(valid),   32'd0);
    check("halt_busy",    32'(busy),    32'd0);
    check("halt_overrun", 32'(overrun), 32'd0);
    check_regs("run");

    // Stall for three cycles at pc 2.
    clear_model();
    start = 1'b1; tick(); start = 1'b0;
    tick(); tick();
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("stall_pc",    32'(pc),    32'd2);
      check("stall_valid", 32'(valid), 32'd1);
      check("stall_dst",   32'(dst),   32'd2);
      check("stall_src1",  32'(src1),  32'd1);
    end
    stall = 1'b0;
    run_to_halt(20);
    check_regs("stall");

    // Asynchronous reset mid-run at pc 4, then rerun.
    clear_model();
    start = 1'b1; tick(); start = 1'b0;
    repeat (4) tick();
    check("pre_rst_pc", 32'(pc), 32'd4);
    #2 reset_n = 1'b0;
    #1;
    check("async_valid", 32'(valid), 32'd0);
    check("async_busy",  32'(busy),  32'd0);
    check("async_pc",    32'(pc),    32'd0);
    tick();
    reset_n = 1'b1;
    clear_model();
    start = 1'b1; tick(); start = 1'b0;
    check("rerun_pc0", 32'(pc), 32'd0);
    run_to_halt(20);
    check("rerun_pc", 32'(pc), 32'd7);
    check_regs("rerun");

    // Load during RUN is ignored.
    clear_model();
    start = 1'b1; tick(); start = 1'b0;
    load_en = 1'b1; load_addr = 5'd1; load_data = mk(0, 1, ALU_XOR, 9, 0, 0, 0);
    tick();
    load_en = 1'b0;
    check("runload_dst", 32'(dst), 32'd1);
    check("runload_imm", 32'(imm), 32'd40);
    run_to_halt(20);
    check("runload_pc", 32'(pc), 32'd7);
    check_regs("runload");

    // Load coinciding with start is dropped.
    #2 reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    clear_model();
    start = 1'b1; load_en = 1'b1; load_addr = 5'd0; load_data = mk(0, 1, ALU_OR, 9, 0, 0, 5);
    tick();
    start = 1'b0; load_en = 1'b0;
    check("ldstart_pc",    32'(pc),              32'd0);
    check("ldstart_ebrk",  32'(flags.is_ebreak), 32'd0);
    check("ldstart_imm",   32'(imm),             32'd10);
    run_to_halt(20);
    check("ldstart_end_pc", 32'(pc), 32'd7);
    check_regs("ldstart");

    // Wrap on the 4-deep instance with no ebreak.
    for (int i = 0; i < 4; i++) begin
      load_en_w = 1'b1; load_addr_w = 2'(i); load_data_w = mk(1, 0, ALU_ADD, 1, 1, 0, i + 1);
      tick();
    end
    load_en_w = 1'b0;
    start_w = 1'b1; tick(); start_w = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check($sformatf("wrap_pc%0d", i),  32'(pc_w),      32'(i % 4));
      check($sformatf("wrap_ovr%0d", i), 32'(overrun_w), (i == 4) ? 32'd1 : 32'd0);
      check($sformatf("wrap_imm%0d", i), 32'(imm_w),     32'((i % 4) + 1));
      tick();
    end
    check("wrap_ovr_sticky", 32'(overrun_w), 32'd1);
    check("wrap_busy",       32'(busy_w),    32'd1);
    #2 reset_n = 1'b0;
    #1;
    check("wrap_ovr_rst", 32'(overrun_w), 32'd0);
    tick();
    reset_n = 1'b1;

`ifdef SEQ_SINGLE_STEP_EN
    // Single-step: one advance per step pulse regardless of pulse length.
    model_en = 1'b0;
    step_mode = 1'b1;
    start = 1'b1; tick(); start = 1'b0;
    check("step_pc0", 32'(pc), 32'd0);
    repeat (3) tick();
    check("step_wait_pc",    32'(pc),    32'd0);
    check("step_wait_valid", 32'(valid), 32'd1);
    step = 1'b1;
    repeat (5) tick();
    check("step_long_pc", 32'(pc), 32'd1);
    step = 1'b0;
    repeat (2) tick();
    check("step_idle_pc", 32'(pc), 32'd1);
    step = 1'b1; tick(); step = 1'b0; tick();
    check("step_short_pc", 32'(pc), 32'd2);
    step_mode = 1'b0;
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
